// File: rtl/write_buffer.sv
// write_buffer
//   Posted-write buffer between a cache and memory. Stores are queued in a
//   small circular FIFO and drained to memory one at a time. A store to the
//   same word as the youngest queued entry is merged into that entry. A read
//   miss can snoop the buffer and forward the youngest matching store.
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   wr_valid_i/_ready_o   store handshake; wr_addr_i / wr_data_i store payload
//   rd_addr_i             read-miss fill address to snoop
//   rd_fwd_hit_o/_data_o  a queued store matches rd_addr_i, and its data
//   mem_req_o, mem_we_o   memory write request (always a write)
//   mem_addr_o/_data_o    head entry being written
//   mem_ack_i             memory completed the presented write
//   empty_o, full_o       occupancy flags
//   count_o               number of queued entries (0..DEPTH)
module write_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_valid_i,
  input  logic [WIDTH-1:0]         wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     wr_ready_o,
  input  logic [WIDTH-1:0]         rd_addr_i,
  output logic                     rd_fwd_hit_o,
  output logic [WIDTH-1:0]         rd_fwd_data_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]         mem_data_o,
  input  logic                     mem_ack_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   head_reg, head_next;
  logic [PTR_W-1:0]   tail_reg, tail_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  // Entry storage is kept in registers rather than block RAM: forwarding
  // must look at every entry combinationally in the same cycle.
  logic [WIDTH-1:0]   addr_mem [DEPTH];
  logic [WIDTH-1:0]   data_mem [DEPTH];

  logic [PTR_W-1:0]   youngest_idx;
  logic               is_full;
  logic               merge_ok;
  logic               accept;
  logic               do_push;
  logic               do_merge;
  logic               do_pop;

  // Byte offset of the snoop address is irrelevant at word granularity.
  logic               unused_rd_low;
  assign unused_rd_low = ^rd_addr_i[1:0];

  // ------------------------------------------------------------------
  // Handshake and merge decision
  // ------------------------------------------------------------------
  assign youngest_idx = tail_reg - PTR_W'(1);
  assign is_full      = (count_reg == CNT_W'(DEPTH));

  // The youngest entry cannot absorb a merge while it is also the head
  // being written to memory: its data is already on the bus.
  assign merge_ok = (count_reg != '0)
                 && (addr_mem[youngest_idx][WIDTH-1:2] == wr_addr_i[WIDTH-1:2])
                 && !((state_reg == ST_REQ) && (count_reg == CNT_W'(1)));

  assign wr_ready_o = !is_full || merge_ok;
  assign accept     = wr_valid_i && wr_ready_o;
  assign do_push    = accept && !merge_ok;
  assign do_merge   = accept && merge_ok;
  assign do_pop     = (state_reg == ST_REQ) && mem_ack_i;

  // ------------------------------------------------------------------
  // Pointers and occupancy
  // ------------------------------------------------------------------
  always_comb begin
    head_next  = do_pop  ? head_reg + PTR_W'(1) : head_reg;
    tail_next  = do_push ? tail_reg + PTR_W'(1) : tail_reg;
    count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if ((count_reg != '0) || accept) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // Stay busy after a pop if anything remains (including a store
        // pushed on the same edge), so writes go out back to back.
        if (do_pop && (count_next == '0)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    mem_req_o  = (state_reg == ST_REQ);
    mem_we_o   = (state_reg == ST_REQ);
    // Head entry is presented unconditionally; it is only meaningful
    // while a request is active.
    mem_addr_o = addr_mem[head_reg];
    mem_data_o = data_mem[head_reg];
  end

  // ------------------------------------------------------------------
  // Entry storage (contents deliberately survive reset; pointers and
  // count define which entries are live)
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_mem[tail_reg] <= wr_addr_i;
      data_mem[tail_reg] <= wr_data_i;
    end else if (do_merge) begin
      data_mem[youngest_idx] <= wr_data_i;
    end
  end

  // ------------------------------------------------------------------
  // Read forwarding
  // ------------------------------------------------------------------
  logic [DEPTH-1:0] entry_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      // Age 0 is the head; an entry is live when its age is below count.
      assign age = PTR_W'(gi) - head_reg;
      assign entry_match[gi] = ({1'b0, age} < count_reg)
                            && (addr_mem[gi][WIDTH-1:2] == rd_addr_i[WIDTH-1:2]);
    end
  endgenerate

  logic [PTR_W-1:0] fwd_idx;

  always_comb begin
    rd_fwd_hit_o  = 1'b0;
    rd_fwd_data_o = '0;
    fwd_idx       = '0;
    // Walk oldest to youngest so the youngest match wins.
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if (entry_match[fwd_idx]) begin
        rd_fwd_hit_o  = 1'b1;
        rd_fwd_data_o = data_mem[fwd_idx];
      end
    end
  end

  // ------------------------------------------------------------------
  // Status
  // ------------------------------------------------------------------
  assign empty_o = (count_reg == '0);
  assign full_o  = is_full;
  assign count_o = count_reg;

endmodule

// File: tb/tb_write_buffer.sv
// Testbench for write_buffer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic [WIDTH-1:0] rd_addr;
  logic             rd_fwd_hit;
  logic [WIDTH-1:0] rd_fwd_data;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             mem_ack;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_valid_i    (wr_valid),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_ready_o    (wr_ready),
    .rd_addr_i     (rd_addr),
    .rd_fwd_hit_o  (rd_fwd_hit),
    .rd_fwd_data_o (rd_fwd_data),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_ack_i     (mem_ack),
    .empty_o       (empty),
    .full_o        (full),
    .count_o       (count)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queued stores oldest-first, plus "a write is on the bus".
  logic [WIDTH-1:0] q_addr[$];
  logic [WIDTH-1:0] q_data[$];
  bit               busy = 1'b0;
  bit               exp_acc;
  bit               exp_merge;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rst_n_v, input bit v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] d, input bit ack, input logic [WIDTH-1:0] ra);
    rst_n    = rst_n_v;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    mem_ack  = ack;
    rd_addr  = ra;
    #1;
  endtask

  // Compare every output against what the model says for the current inputs.
  task automatic model_check();
    int               sz;
    logic [WIDTH-1:0] ya;
    bit               m_ok;
    bit               e_ready;
    bit               hit;
    logic [WIDTH-1:0] fd;
    sz   = q_addr.size();
    m_ok = 1'b0;
    if (sz > 0) begin
      ya   = q_addr[sz-1];
      m_ok = (ya[WIDTH-1:2] == wr_addr[WIDTH-1:2]) && !(busy && sz == 1);
    end
    e_ready = (sz < DEPTH) || m_ok;
    hit = 1'b0;
    fd  = '0;
    foreach (q_addr[i]) begin
      ya = q_addr[i];
      if (ya[WIDTH-1:2] == rd_addr[WIDTH-1:2]) begin
        hit = 1'b1;
        fd  = q_data[i];
      end
    end
    check("wr_ready", wr_ready, e_ready);
    check("mem_req", mem_req, busy);
    check("mem_we", mem_we, busy);
    if (busy) begin
      check("mem_addr", mem_addr, q_addr[0]);
      check("mem_data", mem_data, q_data[0]);
    end
    check("fwd_hit", rd_fwd_hit, hit);
    check("fwd_data", rd_fwd_data, fd);
    check("empty", empty, sz == 0);
    check("full", full, sz == DEPTH);
    check("count", count, sz);
    exp_acc   = wr_valid && e_ready;
    exp_merge = m_ok;
  endtask

  task automatic model_update();
    int  sz0;
    bit  pop;
    if (!rst_n) begin
      q_addr.delete();
      q_data.delete();
      busy = 1'b0;
    end else begin
      sz0 = q_addr.size();
      pop = busy && mem_ack;
      if (exp_acc && exp_merge) q_data[sz0-1] = wr_data;
      if (pop) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (exp_acc && !exp_merge) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
      end
      if (busy) busy = pop ? (q_addr.size() > 0) : 1'b1;
      else      busy = (sz0 > 0) || exp_acc;
    end
  endtask

  task automatic cycle();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step(input bit rst_n_v, input bit v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] d, input bit ack, input logic [WIDTH-1:0] ra);
    set_in(rst_n_v, v, a, d, ack, ra);
    cycle();
  endtask

  task automatic drain();
    for (int n = 0; n < 16 && (q_addr.size() > 0 || busy); n++) begin
      step(1'b1, 1'b0, '0, '0, 1'b1, '0);
    end
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("drain_empty", empty, 1'b1);
    check("drain_idle", mem_req, 1'b0);
    cycle();
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] wa;

    // Initial reset: outputs are unknown before the first edge, so no checks.
    set_in(1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);

    // Reset state
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_fwd_hit", rd_fwd_hit, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_count", count, 0);
    cycle();

    // Single store, latency 1, ack returns to idle
    step(1'b1, 1'b1, 32'h100, 32'hAA, 1'b0, 32'h100);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 32'h100);
    check("single_req", mem_req, 1'b1);
    check("single_addr", mem_addr, 32'h100);
    check("single_data", mem_data, 32'hAA);
    cycle();
    step(1'b1, 1'b0, '0, '0, 1'b1, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("single_idle", mem_req, 1'b0);
    check("single_empty", empty, 1'b1);
    cycle();

    // Fill and back-pressure
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'h100 + 32'(i) * 16, 32'(i + 1), 1'b0, '0);
    end
    set_in(1'b1, 1'b1, 32'h180, 32'h55, 1'b0, '0);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 4);
    check("fill_stall", wr_ready, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("fill_count_held", count, 4);
    cycle();
    drain();

    // Merge behind an in-flight head
    step(1'b1, 1'b1, 32'h100, 32'h11, 1'b0, '0);
    step(1'b1, 1'b1, 32'h200, 32'h1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h200, 32'h2, 1'b0, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("merge_count", count, 2);
    check("merge_head", mem_addr, 32'h100);
    cycle();
    step(1'b1, 1'b0, '0, '0, 1'b1, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("merge_addr", mem_addr, 32'h200);
    check("merge_data", mem_data, 32'h2);
    cycle();
    drain();

    // Forwarding picks the younger of two same-address entries
    step(1'b1, 1'b1, 32'h300, 32'h5, 1'b0, '0);
    step(1'b1, 1'b1, 32'h300, 32'h7, 1'b0, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 32'h300);
    check("fwd_count", count, 2);
    check("fwd_hit_300", rd_fwd_hit, 1'b1);
    check("fwd_data_300", rd_fwd_data, 32'h7);
    cycle();
    drain();

    // Back-to-back drain with ack held high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h400 + 32'(i) * 4, 32'hB0 + 32'(i), 1'b0, '0);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, '0, '0, 1'b1, '0);
      check("b2b_req", mem_req, 1'b1);
      check("b2b_addr", mem_addr, 32'h400 + 32'(i) * 4);
      cycle();
    end
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("b2b_empty", empty, 1'b1);
    check("b2b_idle", mem_req, 1'b0);
    cycle();

    // Reset mid-drain
    step(1'b1, 1'b1, 32'h500, 32'hC0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h504, 32'hC1, 1'b0, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("rstmid_req_before", mem_req, 1'b1);
    check("rstmid_count_before", count, 2);
    cycle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 32'h500);
    check("rstmid_req", mem_req, 1'b0);
    check("rstmid_empty", empty, 1'b1);
    check("rstmid_fwd", rd_fwd_hit, 1'b0);
    cycle();

    // Random traffic over a few words with varying byte offsets
    for (int n = 0; n < 400; n++) begin
      wa = 32'h100 + 32'($urandom_range(0, 2)) * 4 + 32'($urandom_range(0, 3));
      ra = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      step($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0, wa, $urandom,
           $urandom_range(0, 2) == 0, ra);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
